// File: rtl/uart_boot_loader.sv
// UART boot loader: parses a framed program image from the UART byte stream, packs it
// into 16-bit words, writes them to SDRAM and holds the CPU in reset until a good frame.
`timescale 1ns/1ps
module uart_boot_loader #(
  parameter logic [15:0] TIMEOUT = 16'd50000,
  parameter logic [7:0]  SYNC    = 8'h55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_en,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_wr_data,
  output logic        ram_wr_en,
  input  logic        ram_busy,
  output logic        cpu_hold,
  output logic        loader_active,
  output logic        done,
  output logic [1:0]  error
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA_LO, S_DATA_HI, S_CSUM, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [23:0] base_addr;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
  logic [15:0] tmo_cnt;
  logic [7:0]  sum;
  logic [7:0]  data_lo;
  logic        csum_ok;

  logic [7:0] sum_next;
  logic       wr_accept;
  logic       wr_stall;
  logic       receiving;
  logic       timed_out;
  logic       start;

  always_comb begin
    sum_next  = sum + rx_data;
    wr_accept = ram_wr_en & ~ram_busy;
    wr_stall  = ram_wr_en & ram_busy;
    receiving = state inside {S_ADDR, S_LEN, S_DATA_LO, S_DATA_HI, S_CSUM};
    timed_out = receiving && !rx_valid && (tmo_cnt == TIMEOUT - 16'd1);
    start     = rx_valid && (rx_data == SYNC) &&
                ((state == S_IDLE) ? boot_en : (state == S_DONE || state == S_ERROR));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      byte_cnt      <= 2'd0;
      base_addr     <= 24'd0;
      word_cnt      <= 16'd0;
      word_idx      <= 16'd0;
      tmo_cnt       <= 16'd0;
      sum           <= 8'd0;
      data_lo       <= 8'd0;
      csum_ok       <= 1'b0;
      ram_addr      <= 24'd0;
      ram_wr_data   <= 16'd0;
      ram_wr_en     <= 1'b0;
      cpu_hold      <= 1'b1;
      loader_active <= 1'b0;
      done          <= 1'b0;
      error         <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments; a later assignment to ram_wr_en in this block
      // (a freshly completed word) overrides the acceptance clear below.
      if (wr_accept) ram_wr_en <= 1'b0;
      if (receiving) begin
        tmo_cnt <= rx_valid ? 16'd0 : tmo_cnt + 16'd1;
        if (rx_valid) sum <= sum_next;
      end

      if (timed_out) begin
        state         <= S_ERROR;
        error         <= ERR_TIMEOUT;
        loader_active <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (state == S_IDLE) cpu_hold <= boot_en;
            if (start) begin
              state         <= S_ADDR;
              byte_cnt      <= 2'd0;
              sum           <= 8'd0;
              tmo_cnt       <= 16'd0;
              error         <= 2'd0;
              done          <= 1'b0;
              cpu_hold      <= 1'b1;
              loader_active <= 1'b1;
            end
          end
          S_ADDR: if (rx_valid) begin
            base_addr[{byte_cnt, 3'b000} +: 8] <= rx_data;
            if (byte_cnt == 2'd2) begin
              byte_cnt <= 2'd0;
              state    <= S_LEN;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
          S_LEN: if (rx_valid) begin
            if (byte_cnt == 2'd0) begin
              word_cnt[7:0] <= rx_data;
              byte_cnt      <= 2'd1;
            end else begin
              word_cnt[15:8] <= rx_data;
              word_idx       <= 16'd0;
              state          <= ({rx_data, word_cnt[7:0]} == 16'd0) ? S_CSUM : S_DATA_LO;
            end
          end
          S_DATA_LO: if (rx_valid) begin
            data_lo <= rx_data;
            state   <= S_DATA_HI;
          end
          S_DATA_HI: if (rx_valid) begin
            // A word completing while its predecessor is still stalled is an overrun;
            // the stalled write is left to finish on its own.
            if (wr_stall) begin
              state         <= S_ERROR;
              error         <= ERR_OVERRUN;
              loader_active <= 1'b0;
            end else begin
              ram_wr_en   <= 1'b1;
              ram_addr    <= base_addr + {8'd0, word_idx};
              ram_wr_data <= {rx_data, data_lo};
              word_idx    <= word_idx + 16'd1;
              state       <= (word_idx + 16'd1 == word_cnt) ? S_CSUM : S_DATA_LO;
            end
          end
          S_CSUM: if (rx_valid) begin
            csum_ok <= (sum_next == 8'd0);
            if (wr_stall) begin
              state <= S_DRAIN;
            end else begin
              state         <= (sum_next == 8'd0) ? S_DONE : S_ERROR;
              done          <= (sum_next == 8'd0);
              cpu_hold      <= (sum_next != 8'd0);
              error         <= (sum_next == 8'd0) ? 2'd0 : ERR_CSUM;
              loader_active <= 1'b0;
            end
          end
          S_DRAIN: if (!wr_stall) begin
            state         <= csum_ok ? S_DONE : S_ERROR;
            done          <= csum_ok;
            cpu_hold      <= !csum_ok;
            error         <= csum_ok ? 2'd0 : ERR_CSUM;
            loader_active <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table-driven frames, randomized frames against
// a frame-level reference model, and hand-written multi-cycle corner cases.
`timescale 1ns/1ps
module tb_uart_boot_loader;

  localparam logic [15:0] TMO = 16'd100;
  localparam int          GAP = 25;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        boot_en = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [23:0] ram_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en;
  logic        ram_busy = 1'b0;
  logic        cpu_hold;
  logic        loader_active;
  logic        done;
  logic [1:0]  error;

  always #5 clk = ~clk;

  uart_boot_loader #(.TIMEOUT(TMO), .SYNC(8'h55)) dut (
    .clk(clk), .rst(rst), .boot_en(boot_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_busy(ram_busy), .cpu_hold(cpu_hold), .loader_active(loader_active),
    .done(done), .error(error)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit busy_force = 1'b0;
  bit busy_rand  = 1'b0;

  logic [7:0]  fr[$];
  logic [15:0] wd[$];
  logic [23:0] exp_addr[$];
  logic [15:0] exp_data[$];
  logic [23:0] obs_addr[$];
  logic [15:0] obs_data[$];

  typedef struct {
    logic [23:0] base;
    int          n;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [7:0]  delta;
    int          stop;
    bit          rnd_busy;
    logic        exp_done;
    logic [1:0]  exp_err;
    logic        exp_hold;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ram_busy = busy_force ? 1'b1 : (busy_rand ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Write monitor: records accepted writes and checks a stalled request stays frozen.
  logic        prev_stall = 1'b0;
  logic [39:0] prev_word = 40'd0;
  always @(negedge clk) begin
    if (prev_stall)
      check("hold_stable", {ram_wr_en, ram_addr, ram_wr_data}, {1'b1, prev_word});
    prev_stall = !rst && ram_wr_en && ram_busy;
    prev_word  = {ram_addr, ram_wr_data};
    if (!rst && ram_wr_en && !ram_busy) begin
      obs_addr.push_back(ram_addr);
      obs_data.push_back(ram_wr_data);
    end
  end

  // Frame image from the word list: sum of all bytes after SYNC equals delta mod 256.
  task automatic build_frame(input logic [23:0] base, input logic [7:0] delta);
    logic [7:0]  s;
    logic [15:0] n;
    n = 16'(wd.size());
    fr.delete();
    fr.push_back(8'h55);
    fr.push_back(base[7:0]);
    fr.push_back(base[15:8]);
    fr.push_back(base[23:16]);
    fr.push_back(n[7:0]);
    fr.push_back(n[15:8]);
    foreach (wd[i]) begin
      fr.push_back(wd[i][7:0]);
      fr.push_back(wd[i][15:8]);
    end
    s = 8'd0;
    for (int i = 1; i < fr.size(); i++) s = s + fr[i];
    fr.push_back(delta - s);
  endtask

  // Reference model: word i is written once its high byte (byte 7+2i of the frame) arrived.
  task automatic model_writes(input logic [23:0] base, input int sent);
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < wd.size(); i++) begin
      if (6 + 2 * (i + 1) <= sent) begin
        exp_addr.push_back(base + 24'(i));
        exp_data.push_back(wd[i]);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((loader_active || ram_wr_en) && t < 400) begin
      tick();
      t++;
    end
    if (t >= 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_wait: still busy after %0d cycles, expected idle", name, t);
    end
  endtask

  task automatic compare_writes(input string name);
    check({name, "_count"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check({name, "_addr"}, obs_addr[i], exp_addr[i]);
      check({name, "_data"}, obs_data[i], exp_data[i]);
    end
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic run_frame(input string name, input logic [23:0] base, input logic [7:0] delta,
                           input int stop);
    int sent;
    clear_obs();
    build_frame(base, delta);
    sent = (stop < 0) ? fr.size() : stop;
    for (int i = 0; i < sent; i++) send_byte(fr[i], GAP);
    model_writes(base, sent);
    wait_idle(name);
    compare_writes(name);
  endtask

  task automatic check_status(input string name, input logic d, input logic [1:0] e,
                              input logic h);
    check({name, "_done"}, done, d);
    check({name, "_error"}, error, e);
    check({name, "_hold"}, cpu_hold, h);
    check({name, "_active"}, loader_active, 1'b0);
  endtask

  initial begin
    vt[0] = '{24'h000010, 2, 16'h1234, 16'h5678, 8'd0,   -1, 1'b0, 1'b1, 2'd0, 1'b0};
    vt[1] = '{24'h000010, 2, 16'h1234, 16'h5678, 8'd1,   -1, 1'b0, 1'b0, 2'd1, 1'b1};
    vt[2] = '{24'hFFFFFF, 2, 16'hABCD, 16'hEF01, 8'd0,   -1, 1'b1, 1'b1, 2'd0, 1'b0};
    vt[3] = '{24'h000100, 0, 16'h0000, 16'h0000, 8'd0,   -1, 1'b0, 1'b1, 2'd0, 1'b0};
    vt[4] = '{24'h000020, 2, 16'h1111, 16'h2222, 8'd0,    3, 1'b0, 1'b0, 2'd2, 1'b1};
    vt[5] = '{24'h123456, 3, 16'h0F0F, 16'hF0F0, 8'd0,   -1, 1'b1, 1'b1, 2'd0, 1'b0};
    vt[6] = '{24'h000040, 3, 16'h4444, 16'h5555, 8'd0,    9, 1'b0, 1'b0, 2'd2, 1'b1};
    vt[7] = '{24'hFFFFFE, 3, 16'h7777, 16'h8888, 8'h80,  -1, 1'b1, 1'b0, 2'd1, 1'b1};

    // Reset values with the loader bypassed, then release.
    repeat (3) tick();
    check("rst_wr_en", ram_wr_en, 1'b0);
    check("rst_addr", ram_addr, 24'd0);
    check("rst_data", ram_wr_data, 16'd0);
    check("rst_hold", cpu_hold, 1'b1);
    check("rst_active", loader_active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 2'd0);
    rst = 1'b0;
    check("bypass_hold_pre", cpu_hold, 1'b1);
    tick();
    check("bypass_hold_post", cpu_hold, 1'b0);
    clear_obs();
    foreach (vt[i]) ;
    begin
      logic [7:0] bp[9];
      bp = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
      for (int i = 0; i < 9; i++) send_byte(bp[i], GAP);
    end
    check("bypass_writes", obs_addr.size(), 0);
    check("bypass_active", loader_active, 1'b0);
    check("bypass_hold", cpu_hold, 1'b0);

    // Reset with boot enabled: the CPU stays held through release.
    boot_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("boot_hold", cpu_hold, 1'b1);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      wd.delete();
      for (int j = 0; j < vt[i].n; j++)
        wd.push_back(j == 0 ? vt[i].w0 : (j == 1 ? vt[i].w1 : 16'($urandom)));
      busy_rand = vt[i].rnd_busy;
      run_frame($sformatf("tbl%0d", i), vt[i].base, vt[i].delta, vt[i].stop);
      busy_rand = 1'b0;
      check_status($sformatf("tbl%0d", i), vt[i].exp_done, vt[i].exp_err, vt[i].exp_hold);
    end

    // Randomized frames against the reference model.
    busy_rand = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [23:0] base;
      logic [7:0]  delta;
      int          n;
      base  = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 3))
                                          : 24'($urandom);
      n     = $urandom_range(0, 5);
      delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      wd.delete();
      for (int j = 0; j < n; j++) wd.push_back(16'($urandom));
      run_frame($sformatf("rnd%0d", k), base, delta, -1);
      check_status($sformatf("rnd%0d", k), delta == 8'd0,
                   (delta == 8'd0) ? 2'd0 : 2'd1, delta != 8'd0);
    end
    busy_rand = 1'b0;

    // Write held across 20 busy cycles, accepted on the first free cycle.
    clear_obs();
    wd.delete();
    wd.push_back(16'hBEEF);
    build_frame(24'h000200, 8'd0);
    for (int i = 0; i < 7; i++) send_byte(fr[i], GAP);
    busy_force = 1'b1;
    ram_busy   = 1'b1;
    check("busy_pre", ram_wr_en, 1'b0);
    rx_data  = fr[7];
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("busy_rise", {ram_wr_en, ram_addr, ram_wr_data}, {1'b1, 24'h000200, 16'hBEEF});
    repeat (19) tick();
    check("busy_held", {ram_wr_en, ram_addr, ram_wr_data}, {1'b1, 24'h000200, 16'hBEEF});
    busy_force = 1'b0;
    ram_busy   = 1'b0;
    tick();
    check("busy_drop", ram_wr_en, 1'b0);
    check("busy_count", obs_addr.size(), 1);
    check("busy_no_overrun", error, 2'd0);
    send_byte(fr[8], GAP);
    wait_idle("busy");
    model_writes(24'h000200, fr.size());
    compare_writes("busy");
    check_status("busy", 1'b1, 2'd0, 1'b0);

    // Word completing on its predecessor's acceptance cycle, then a real overrun.
    clear_obs();
    wd.delete();
    wd.push_back(16'h1111);
    wd.push_back(16'h2222);
    wd.push_back(16'h3333);
    build_frame(24'h000300, 8'd0);
    for (int i = 0; i < 7; i++) send_byte(fr[i], GAP);
    busy_force = 1'b1;
    ram_busy   = 1'b1;
    send_byte(fr[7], GAP);
    send_byte(fr[8], GAP);
    busy_force = 1'b0;
    ram_busy   = 1'b0;
    rx_data    = fr[9];
    rx_valid   = 1'b1;
    tick();
    rx_valid   = 1'b0;
    busy_force = 1'b1;
    ram_busy   = 1'b1;
    check("same_cycle_error", error, 2'd0);
    check("same_cycle_next", {ram_wr_en, ram_addr, ram_wr_data}, {1'b1, 24'h000301, 16'h2222});
    check("same_cycle_first", obs_addr.size(), 1);
    repeat (GAP) tick();
    send_byte(fr[10], GAP);
    rx_data  = fr[11];
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("overrun_error", error, 2'd3);
    check("overrun_active", loader_active, 1'b0);
    check("overrun_hold", cpu_hold, 1'b1);
    check("overrun_pending", {ram_wr_en, ram_addr}, {1'b1, 24'h000301});
    busy_force = 1'b0;
    wait_idle("overrun");
    model_writes(24'h000300, 10);
    compare_writes("overrun");
    check_status("overrun", 1'b0, 2'd3, 1'b1);

    // Timeout fires exactly TIMEOUT cycles after the last byte, then recovery.
    wd.delete();
    build_frame(24'hABCDEF, 8'd0);
    send_byte(fr[0], GAP);
    send_byte(fr[1], GAP);
    send_byte(fr[2], 0);
    repeat (99) tick();
    check("tmo_early_error", error, 2'd0);
    check("tmo_early_active", loader_active, 1'b1);
    tick();
    check_status("tmo", 1'b0, 2'd2, 1'b1);
    wd.delete();
    wd.push_back(16'h0A0B);
    run_frame("recover", 24'h000500, 8'd0, -1);
    check_status("recover", 1'b1, 2'd0, 1'b0);

    // Reset mid-frame drops the outstanding request at the reset edge.
    clear_obs();
    wd.delete();
    wd.push_back(16'hCAFE);
    wd.push_back(16'hF00D);
    build_frame(24'h000600, 8'd0);
    for (int i = 0; i < 7; i++) send_byte(fr[i], GAP);
    busy_force = 1'b1;
    ram_busy   = 1'b1;
    send_byte(fr[7], 3);
    check("midrst_pending", ram_wr_en, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_wr_en", ram_wr_en, 1'b0);
    check("midrst_addr", ram_addr, 24'd0);
    check_status("midrst", 1'b0, 2'd0, 1'b1);
    rst = 1'b0;
    busy_force = 1'b0;
    tick();
    tick();
    check("midrst_writes", obs_addr.size(), 0);
    check("midrst_hold", cpu_hold, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
